// File: rtl/riscv_branch_predictor_if.sv
// riscv_branch_predictor_if: fetch lookup, MEM resolution and statistics bundle
interface riscv_branch_predictor_if #(parameter int CNT_W = 16);
  logic [31:0] pc_i;
  logic pred_taken_o;
  logic [31:0] pred_target_o;
  logic res_valid_i;
  logic [31:0] res_pc_i;
  logic [2:0] res_BranchOp_i;
  logic res_taken_i;
  logic [31:0] res_target_i;
  logic res_pred_taken_i;
  logic [31:0] res_pred_target_i;
  logic mispredict_o;
  logic flush_o;
  logic [31:0] redirect_pc_o;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;
  modport master (
    output pc_i, res_valid_i, res_pc_i, res_BranchOp_i, res_taken_i, res_target_i,
           res_pred_taken_i, res_pred_target_i,
    input pred_taken_o, pred_target_o, mispredict_o, flush_o, redirect_pc_o,
          br_cnt_o, miss_cnt_o
  );
  modport slave (
    input pc_i, res_valid_i, res_pc_i, res_BranchOp_i, res_taken_i, res_target_i,
          res_pred_taken_i, res_pred_target_i,
    output pred_taken_o, pred_target_o, mispredict_o, flush_o, redirect_pc_o,
           br_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/riscv_branch_predictor.sv
// riscv_branch_predictor: direct-mapped BTB with 2-bit counters, MEM-stage mispredict detection and stats
module riscv_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  riscv_branch_predictor_if.slave b
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW = 30 - IDX;
  logic valid_q [ENTRIES];
  logic [TW-1:0] tag_q [ENTRIES];
  logic [31:0] target_q [ENTRIES];
  logic [1:0] ctr_q [ENTRIES];
  logic [CNT_W-1:0] br_cnt, miss_cnt;
  logic [IDX-1:0] idx, ridx;
  logic [TW-1:0] rtag;
  logic hit, rhit, ev, mis;
  // Fetch lookup against registered table state; forced to fall-through during reset
  always_comb begin
    idx = b.pc_i[IDX+1:2];
    hit = valid_q[idx] && tag_q[idx] == b.pc_i[31:IDX+2];
    b.pred_taken_o = !rst && hit && ctr_q[idx][1];
    b.pred_target_o = b.pred_taken_o ? target_q[idx] : b.pc_i + 32'd4;
  end
  // Resolution compare against the prediction that travelled with the instruction
  always_comb begin
    ridx = b.res_pc_i[IDX+1:2];
    rtag = b.res_pc_i[31:IDX+2];
    rhit = valid_q[ridx] && tag_q[ridx] == rtag;
    ev = !rst && b.res_valid_i && b.res_BranchOp_i != 3'b000;
    mis = ev && (b.res_taken_i != b.res_pred_taken_i ||
                 (b.res_taken_i && b.res_target_i != b.res_pred_target_i));
    b.mispredict_o = mis;
    b.flush_o = mis;
    b.redirect_pc_o = rst ? 32'd0 : b.res_taken_i ? b.res_target_i : b.res_pc_i + 32'd4;
    b.br_cnt_o = br_cnt;
    b.miss_cnt_o = miss_cnt;
  end
  // Table training and saturating statistics; a reset cycle swallows any event
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i] <= 2'b00;
      end
      br_cnt <= '0;
      miss_cnt <= '0;
    end else if (ev) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (mis && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      if (b.res_BranchOp_i == 3'b001) begin
        valid_q[ridx] <= 1'b1;
        tag_q[ridx] <= rtag;
        target_q[ridx] <= b.res_target_i;
        ctr_q[ridx] <= 2'b11;
      end else if (b.res_BranchOp_i[2] && rhit) begin
        ctr_q[ridx] <= b.res_taken_i ? (ctr_q[ridx] == 2'b11 ? 2'b11 : ctr_q[ridx] + 2'd1)
                                     : (ctr_q[ridx] == 2'b00 ? 2'b00 : ctr_q[ridx] - 2'd1);
        if (b.res_taken_i) target_q[ridx] <= b.res_target_i;
      end else if (b.res_BranchOp_i[2] && b.res_taken_i) begin
        valid_q[ridx] <= 1'b1;
        tag_q[ridx] <= rtag;
        target_q[ridx] <= b.res_target_i;
        ctr_q[ridx] <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_riscv_branch_predictor.sv
// tb_riscv_branch_predictor: directed scoreboard bench for the branch predictor
module tb_riscv_branch_predictor;
  typedef struct {string tag; logic [31:0] v;} ent_t;
  ent_t sb[$];
  int tests = 0;
  int fails = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  riscv_branch_predictor_if #(.CNT_W(16)) bus ();
  riscv_branch_predictor #(.ENTRIES(16), .CNT_W(16)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  task automatic push(input string t, input logic [31:0] v);
    ent_t e;
    e.tag = t;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic chk(input logic [31:0] obs);
    ent_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic ev(input logic [2:0] op, input logic [31:0] pc, input logic tk,
                    input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    bus.res_valid_i = 1'b1;
    bus.res_BranchOp_i = op;
    bus.res_pc_i = pc;
    bus.res_taken_i = tk;
    bus.res_target_i = tg;
    bus.res_pred_taken_i = ptk;
    bus.res_pred_target_i = ptg;
  endtask
  task automatic idle();
    bus.res_valid_i = 1'b0;
    bus.res_BranchOp_i = 3'b000;
  endtask
  initial begin
    bus.pc_i = 32'h100;
    bus.res_pc_i = 32'h0;
    bus.res_taken_i = 1'b0;
    bus.res_target_i = 32'h0;
    bus.res_pred_taken_i = 1'b0;
    bus.res_pred_target_i = 32'h0;
    idle();
    @(negedge clk);
    @(negedge clk);
    ev(3'b100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    push("rst_pred_taken", 0); push("rst_pred_target", 32'h104);
    push("rst_mispredict", 0); push("rst_flush", 0); push("rst_redirect", 0);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o);
    chk(bus.mispredict_o); chk(bus.flush_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    rst = 1'b0;
    idle();
    push("post_rst_taken", 0); push("post_rst_target", 32'h104);
    push("post_rst_br", 0); push("post_rst_miss", 0);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o); chk(bus.br_cnt_o); chk(bus.miss_cnt_o);
    @(negedge clk);
    ev(3'b100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    push("beq1_mis", 1); push("beq1_flush", 1); push("beq1_redirect", 32'h80);
    push("beq1_no_bypass", 0);
    #1;
    chk(bus.mispredict_o); chk(bus.flush_o); chk(bus.redirect_pc_o); chk(bus.pred_taken_o);
    @(negedge clk);
    idle();
    push("beq1_lookup_taken", 1); push("beq1_lookup_target", 32'h80);
    push("beq1_br", 1); push("beq1_miss", 1);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o); chk(bus.br_cnt_o); chk(bus.miss_cnt_o);
    @(negedge clk);
    ev(3'b100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    push("nt1_mis", 1); push("nt1_redirect", 32'h104);
    #1;
    chk(bus.mispredict_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    ev(3'b100, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    push("nt2_mis", 0); push("ctr01_lookup", 0);
    #1;
    chk(bus.mispredict_o); chk(bus.pred_taken_o);
    @(negedge clk);
    idle();
    push("ctr00_lookup", 0); push("ctr00_target", 32'h104); push("nt_br", 3); push("nt_miss", 2);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o); chk(bus.br_cnt_o); chk(bus.miss_cnt_o);
    @(negedge clk);
    ev(3'b100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    push("sat00_mis", 1);
    #1;
    chk(bus.mispredict_o);
    @(negedge clk);
    idle();
    push("sat00_then_01", 0);
    #1;
    chk(bus.pred_taken_o);
    @(negedge clk);
    ev(3'b010, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    bus.pc_i = 32'h200;
    push("jalr_mis", 1); push("jalr_redirect", 32'h300);
    #1;
    chk(bus.mispredict_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    idle();
    push("jalr_no_train", 0); push("jalr_target", 32'h204); push("jalr_br", 5); push("jalr_miss", 4);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o); chk(bus.br_cnt_o); chk(bus.miss_cnt_o);
    @(negedge clk);
    ev(3'b001, 32'h184, 1'b1, 32'h400, 1'b1, 32'h400);
    push("jal_no_mis", 0);
    #1;
    chk(bus.mispredict_o);
    @(negedge clk);
    idle();
    bus.pc_i = 32'h184;
    push("jal_taken", 1); push("jal_target", 32'h400);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o);
    @(negedge clk);
    ev(3'b100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    push("beq_re_mis", 1);
    #1;
    chk(bus.mispredict_o);
    @(negedge clk);
    idle();
    bus.pc_i = 32'h100;
    push("beq_ctr10_taken", 1); push("beq_ctr10_target", 32'h80);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o);
    @(negedge clk);
    ev(3'b101, 32'h140, 1'b1, 32'h40, 1'b0, 32'h144);
    push("bne_alias_mis", 1); push("bne_alias_redirect", 32'h40);
    #1;
    chk(bus.mispredict_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    idle();
    push("evicted_taken", 0); push("evicted_target", 32'h104);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o);
    bus.pc_i = 32'h140;
    push("alias_new_taken", 1); push("alias_new_target", 32'h40);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o);
    @(negedge clk);
    ev(3'b110, 32'h208, 1'b0, 32'h600, 1'b0, 32'h20C);
    push("blt_nt_mis", 0); push("blt_nt_redirect", 32'h20C);
    #1;
    chk(bus.mispredict_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    idle();
    bus.pc_i = 32'h208;
    push("blt_nt_no_alloc", 0); push("blt_br", 9); push("blt_miss", 6);
    #1;
    chk(bus.pred_taken_o); chk(bus.br_cnt_o); chk(bus.miss_cnt_o);
    @(negedge clk);
    ev(3'b111, 32'h20C, 1'b1, 32'h500, 1'b0, 32'h210);
    push("bge1_mis", 1);
    #1;
    chk(bus.mispredict_o);
    @(negedge clk);
    ev(3'b111, 32'h20C, 1'b1, 32'h500, 1'b1, 32'h500);
    push("bge2_mis", 0);
    #1;
    chk(bus.mispredict_o);
    @(negedge clk);
    ev(3'b111, 32'h20C, 1'b1, 32'h520, 1'b1, 32'h500);
    push("bge3_target_mis", 1); push("bge3_redirect", 32'h520);
    #1;
    chk(bus.mispredict_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    ev(3'b111, 32'h20C, 1'b0, 32'h520, 1'b1, 32'h520);
    push("bge4_mis", 1);
    #1;
    chk(bus.mispredict_o);
    @(negedge clk);
    idle();
    bus.pc_i = 32'h20C;
    push("b2b_taken", 1); push("b2b_target", 32'h520); push("b2b_br", 13); push("b2b_miss", 9);
    #1;
    chk(bus.pred_taken_o); chk(bus.pred_target_o); chk(bus.br_cnt_o); chk(bus.miss_cnt_o);
    bus.pc_i = 32'hFFFF_FFFC;
    push("wrap_target", 32'h0);
    #1;
    chk(bus.pred_target_o);
    for (int i = 0; i < 65535 - 9; i++) begin
      @(negedge clk);
      ev(3'b010, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    end
    @(negedge clk);
    idle();
    push("miss_at_max", 32'hFFFF); push("br_at_max", 32'hFFFF);
    #1;
    chk(bus.miss_cnt_o); chk(bus.br_cnt_o);
    @(negedge clk);
    ev(3'b010, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    @(negedge clk);
    idle();
    push("miss_saturated", 32'hFFFF); push("br_saturated", 32'hFFFF);
    #1;
    chk(bus.miss_cnt_o); chk(bus.br_cnt_o);
    @(negedge clk);
    rst = 1'b1;
    ev(3'b100, 32'h30C, 1'b1, 32'h600, 1'b0, 32'h310);
    bus.pc_i = 32'h30C;
    push("rst_ev_mis", 0); push("rst_ev_flush", 0); push("rst_ev_redirect", 0);
    #1;
    chk(bus.mispredict_o); chk(bus.flush_o); chk(bus.redirect_pc_o);
    @(negedge clk);
    rst = 1'b0;
    idle();
    push("rst_ev_no_train", 0); push("rst_ev_miss", 0); push("rst_ev_br", 0);
    #1;
    chk(bus.pred_taken_o); chk(bus.miss_cnt_o); chk(bus.br_cnt_o);
    bus.pc_i = 32'h140;
    push("rst_cleared_valid", 0);
    #1;
    chk(bus.pred_taken_o);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
